// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings,
// bubble word, PC step and the default reset vector.
package if_fetch_unit_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at req_addr
    HOLD  = 2'd1,  // stall caught a completed fetch; result parked in the buffer
    DRAIN = 2'd2   // redirect made the outstanding request stale; wait and discard
  } fetch_state_e;

  // Bubble inserted into the IF/ID register when no instruction is ready.
  localparam logic [31:0] ZEROWORD          = 32'h0000_0000;
  // Distance between sequential instructions.
  localparam logic [31:0] INSTR_STEP        = 32'd4;
  // Fetch PC after reset.
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  // Sequential successor of a PC (32-bit modulo, wraps at the top).
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + INSTR_STEP;
  endfunction

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface if_fetch_unit_if;

  logic        imem_req_o;    // request valid
  logic [31:0] imem_addr_o;   // request address, stable while imem_req_o=1
  logic        imem_ack_i;    // request complete this cycle
  logic [31:0] imem_rdata_i;  // fetched instruction, valid with imem_ack_i

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/if_fetch_unit_hold_buf.sv
// One-entry instruction/PC buffer. Parks an instruction that completed
// while the pipeline was stalled so it can be presented on release.
module if_hold_buf
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] instr_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        valid_q;
  logic        valid_d;

  // Next contents: a load wins over a clear issued in the same cycle.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end else if (clear_i) begin
      instr_d = ZEROWORD;
      pc_d    = 32'h0000_0000;
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Buffer storage with synchronous reset to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= ZEROWORD;
      pc_q    <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the req/ack handshake
// with instruction memory and presents a (PC, instruction) pair or a bubble
// to the IF/ID register, honouring redirect (jump_flag) and stall
// (load_use_flag). Optional feature macro: FETCH_ALIGN_CHECK_EN (word-align
// redirect targets and flag misaligned ones on misalign_o).
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_flag,
  input  logic [31:0]            jump_addr_i,
  input  logic                   load_use_flag,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            pc_if_o,
  output logic [31:0]            instr_if_o,
  output logic                   misalign_o
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  fetch_pc_d;
  logic [31:0]  req_addr_q;
  logic [31:0]  req_addr_d;
  logic [31:0]  pc_if_q;
  logic [31:0]  pc_if_d;
  logic [31:0]  instr_if_q;
  logic [31:0]  instr_if_d;

  logic         ack_s;
  logic [31:0]  rdata_s;
  logic [31:0]  jump_tgt_s;
  logic         buf_load_s;
  logic         buf_clear_s;
  logic [31:0]  buf_instr_s;
  logic [31:0]  buf_pc_s;
  logic         buf_valid_s;

  assign ack_s   = imem.imem_ack_i;
  assign rdata_s = imem.imem_rdata_i;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_d;

  assign jump_tgt_s = align_word(jump_addr_i);

  // Flag a redirect whose target was not word aligned.
  always_comb begin
    if (jump_flag) begin
      misalign_d = (jump_addr_i[1:0] != 2'b00);
    end else begin
      misalign_d = 1'b0;
    end
  end

  // One-cycle registered misalignment pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign jump_tgt_s = jump_addr_i;
  assign misalign_o = 1'b0;
`endif

  // Holding buffer for a fetch that completes during a stall.
  if_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load_s),
    .clear_i (buf_clear_s),
    .instr_i (rdata_s),
    .pc_i    (req_addr_q),
    .instr_o (buf_instr_s),
    .pc_o    (buf_pc_s),
    .valid_o (buf_valid_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; priority jump_flag > load_use_flag > normal.
  always_comb begin
    state_d = state_q;
    if (jump_flag) begin
      case (state_q)
        FETCH:   state_d = ack_s ? FETCH : DRAIN;
        HOLD:    state_d = FETCH;
        DRAIN:   state_d = ack_s ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else if (load_use_flag) begin
      case (state_q)
        FETCH:   state_d = ack_s ? HOLD : FETCH;
        HOLD:    state_d = HOLD;
        DRAIN:   state_d = ack_s ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH:   state_d = FETCH;
        HOLD:    state_d = FETCH;
        DRAIN:   state_d = ack_s ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end
  end

  // Datapath / output next values. A redirect never rewrites the address
  // of a request still in flight: while one is outstanding the target is
  // parked in fetch_pc and copied into req_addr when the stale ack drains.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    pc_if_d     = pc_if_q;
    instr_if_d  = instr_if_q;
    buf_load_s  = 1'b0;
    buf_clear_s = 1'b0;
    if (jump_flag) begin
      fetch_pc_d  = jump_tgt_s;
      instr_if_d  = ZEROWORD;
      buf_clear_s = 1'b1;
      case (state_q)
        FETCH: begin
          if (ack_s) req_addr_d = jump_tgt_s;
          else       req_addr_d = req_addr_q;
        end
        HOLD:  req_addr_d = jump_tgt_s;
        DRAIN: begin
          if (ack_s) req_addr_d = jump_tgt_s;
          else       req_addr_d = req_addr_q;
        end
        default: req_addr_d = jump_tgt_s;
      endcase
    end else if (load_use_flag) begin
      case (state_q)
        FETCH: begin
          if (ack_s) begin
            buf_load_s = 1'b1;
            fetch_pc_d = next_pc(req_addr_q);
          end else begin
            fetch_pc_d = fetch_pc_q;
          end
        end
        HOLD: fetch_pc_d = fetch_pc_q;
        DRAIN: begin
          instr_if_d = ZEROWORD;
          if (ack_s) req_addr_d = fetch_pc_q;
          else       req_addr_d = req_addr_q;
        end
        default: fetch_pc_d = fetch_pc_q;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (ack_s) begin
            pc_if_d    = req_addr_q;
            instr_if_d = rdata_s;
            fetch_pc_d = next_pc(req_addr_q);
            req_addr_d = next_pc(req_addr_q);
          end else begin
            instr_if_d = ZEROWORD;
          end
        end
        HOLD: begin
          if (buf_valid_s) begin
            pc_if_d    = buf_pc_s;
            instr_if_d = buf_instr_s;
          end else begin
            instr_if_d = ZEROWORD;
          end
          req_addr_d  = fetch_pc_q;
          buf_clear_s = 1'b1;
        end
        DRAIN: begin
          instr_if_d = ZEROWORD;
          if (ack_s) req_addr_d = fetch_pc_q;
          else       req_addr_d = req_addr_q;
        end
        default: instr_if_d = ZEROWORD;
      endcase
    end
  end

  // Fetch PC, request address and presented pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_VEC;
      req_addr_q <= RESET_VEC;
      pc_if_q    <= 32'h0000_0000;
      instr_if_q <= ZEROWORD;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      pc_if_q    <= pc_if_d;
      instr_if_q <= instr_if_d;
    end
  end

  assign imem.imem_req_o  = ((state_q == FETCH) || (state_q == DRAIN)) && !rst;
  assign imem.imem_addr_o = req_addr_q;
  assign pc_if_o          = pc_if_q;
  assign instr_if_o       = instr_if_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr_i;
  logic        load_use_flag;
  logic [31:0] pc_if_o;
  logic [31:0] instr_if_o;
  logic        misalign_o;
  int          n_cmp;
  int          n_err;

  if_fetch_unit_if imem_bus ();

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] MIS_ADDR = 32'h0000_0100;
  localparam logic        MIS_FLAG = 1'b1;
`else
  localparam logic [31:0] MIS_ADDR = 32'h0000_0103;
  localparam logic        MIS_FLAG = 1'b0;
`endif

  if_fetch_unit #(.RESET_VEC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag     (jump_flag),
    .jump_addr_i   (jump_addr_i),
    .load_use_flag (load_use_flag),
    .imem          (imem_bus),
    .pc_if_o       (pc_if_o),
    .instr_if_o    (instr_if_o),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] ins(input logic [31:0] a);
    return 32'h1300_0000 ^ a;
  endfunction

  task automatic drive(input logic r, input logic jf, input logic [31:0] ja,
                       input logic lu, input logic ack, input logic [31:0] rd);
    rst = r; jump_flag = jf; jump_addr_i = ja; load_use_flag = lu;
    imem_bus.imem_ack_i = ack; imem_bus.imem_rdata_i = rd;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (imem_bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b exp 0", imem_bus.imem_req_o); end
    tick(); tick();
    n_cmp++; if (instr_if_o !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h exp 0", instr_if_o); end
    n_cmp++; if (pc_if_o !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h exp 0", pc_if_o); end
    n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL rst_mis: got %b exp 0", misalign_o); end
    n_cmp++; if (imem_bus.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h exp 0", imem_bus.imem_addr_o); end
  endtask

  task automatic test_stream;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ins(a));
      n_cmp++; if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== a) begin n_err++; $display("FAIL stream_req%0d: got %b/%h exp 1/%h", i, imem_bus.imem_req_o, imem_bus.imem_addr_o, a); end
      tick();
      n_cmp++; if (pc_if_o !== a || instr_if_o !== ins(a)) begin n_err++; $display("FAIL stream_out%0d: got %h/%h exp %h/%h", i, pc_if_o, instr_if_o, a, ins(a)); end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ins(32'hC));
    tick();
  endtask

  task automatic test_wait_state;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
      n_cmp++; if (imem_bus.imem_addr_o !== 32'h10 || imem_bus.imem_req_o !== 1'b1) begin n_err++; $display("FAIL wait_addr%0d: got %b/%h exp 1/00000010", i, imem_bus.imem_req_o, imem_bus.imem_addr_o); end
      tick();
      n_cmp++; if (instr_if_o !== 32'h0 || pc_if_o !== 32'hC) begin n_err++; $display("FAIL wait_bubble%0d: got %h/%h exp 0000000c/00000000", i, pc_if_o, instr_if_o); end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ins(32'h10));
    n_cmp++; if (imem_bus.imem_addr_o !== 32'h10) begin n_err++; $display("FAIL wait_addr_ack: got %h exp 00000010", imem_bus.imem_addr_o); end
    tick();
    n_cmp++; if (pc_if_o !== 32'h10 || instr_if_o !== ins(32'h10)) begin n_err++; $display("FAIL wait_out: got %h/%h exp 00000010/%h", pc_if_o, instr_if_o, ins(32'h10)); end
  endtask

  task automatic test_stall;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ins(32'h14));
    n_cmp++; if (imem_bus.imem_addr_o !== 32'h14) begin n_err++; $display("FAIL stall_addr: got %h exp 00000014", imem_bus.imem_addr_o); end
    tick();
    n_cmp++; if (pc_if_o !== 32'h10 || instr_if_o !== ins(32'h10)) begin n_err++; $display("FAIL stall_frz1: got %h/%h exp 00000010/%h", pc_if_o, instr_if_o, ins(32'h10)); end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (imem_bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL stall_hold_req: got %b exp 0", imem_bus.imem_req_o); end
    tick();
    n_cmp++; if (pc_if_o !== 32'h10 || instr_if_o !== ins(32'h10)) begin n_err++; $display("FAIL stall_frz2: got %h/%h exp 00000010/%h", pc_if_o, instr_if_o, ins(32'h10)); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (pc_if_o !== 32'h14 || instr_if_o !== ins(32'h14)) begin n_err++; $display("FAIL stall_release: got %h/%h exp 00000014/%h", pc_if_o, instr_if_o, ins(32'h14)); end
    n_cmp++; if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h18) begin n_err++; $display("FAIL stall_next_req: got %b/%h exp 1/00000018", imem_bus.imem_req_o, imem_bus.imem_addr_o); end
  endtask

  task automatic test_jump_acked;
    drive(1'b0, 1'b1, 32'h40, 1'b0, 1'b1, ins(32'h18));
    tick();
    n_cmp++; if (instr_if_o !== 32'h0 || pc_if_o !== 32'h14) begin n_err++; $display("FAIL jack_out: got %h/%h exp 00000014/00000000", pc_if_o, instr_if_o); end
    n_cmp++; if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h40) begin n_err++; $display("FAIL jack_req: got %b/%h exp 1/00000040", imem_bus.imem_req_o, imem_bus.imem_addr_o); end
  endtask

  task automatic test_drain;
    drive(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    tick();
    n_cmp++; if (instr_if_o !== 32'h0) begin n_err++; $display("FAIL drain_bub0: got %h exp 0", instr_if_o); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h40) begin n_err++; $display("FAIL drain_hold_addr: got %b/%h exp 1/00000040", imem_bus.imem_req_o, imem_bus.imem_addr_o); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ins(32'h40));
    tick();
    n_cmp++; if (instr_if_o !== 32'h0 || pc_if_o !== 32'h14) begin n_err++; $display("FAIL drain_discard: got %h/%h exp 00000014/00000000", pc_if_o, instr_if_o); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h200) begin n_err++; $display("FAIL drain_target: got %b/%h exp 1/00000200", imem_bus.imem_req_o, imem_bus.imem_addr_o); end
    tick();
    n_cmp++; if (instr_if_o !== 32'h0) begin n_err++; $display("FAIL drain_bub1: got %h exp 0", instr_if_o); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ins(32'h200));
    tick();
    n_cmp++; if (pc_if_o !== 32'h200 || instr_if_o !== ins(32'h200)) begin n_err++; $display("FAIL drain_out: got %h/%h exp 00000200/%h", pc_if_o, instr_if_o, ins(32'h200)); end
  endtask

  task automatic test_jump_and_stall;
    drive(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, ins(32'h204));
    tick();
    n_cmp++; if (instr_if_o !== 32'h0 || pc_if_o !== 32'h200) begin n_err++; $display("FAIL js_bubble: got %h/%h exp 00000200/00000000", pc_if_o, instr_if_o); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ins(32'h300));
    n_cmp++; if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h300) begin n_err++; $display("FAIL js_req: got %b/%h exp 1/00000300", imem_bus.imem_req_o, imem_bus.imem_addr_o); end
    tick();
    n_cmp++; if (pc_if_o !== 32'h300 || instr_if_o !== ins(32'h300)) begin n_err++; $display("FAIL js_out: got %h/%h exp 00000300/%h", pc_if_o, instr_if_o, ins(32'h300)); end
  endtask

  task automatic test_misalign;
    drive(1'b0, 1'b1, 32'h103, 1'b0, 1'b1, ins(32'h304));
    tick();
    n_cmp++; if (misalign_o !== MIS_FLAG) begin n_err++; $display("FAIL mis_pulse: got %b exp %b", misalign_o, MIS_FLAG); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (imem_bus.imem_addr_o !== MIS_ADDR) begin n_err++; $display("FAIL mis_addr: got %h exp %h", imem_bus.imem_addr_o, MIS_ADDR); end
    tick();
    n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b exp 0", misalign_o); end
  endtask

  task automatic test_wrap;
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ins(32'hFFFF_FFFC));
    n_cmp++; if (imem_bus.imem_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req: got %h exp fffffffc", imem_bus.imem_addr_o); end
    tick();
    n_cmp++; if (pc_if_o !== 32'hFFFF_FFFC || instr_if_o !== ins(32'hFFFF_FFFC)) begin n_err++; $display("FAIL wrap_out: got %h/%h exp fffffffc/%h", pc_if_o, instr_if_o, ins(32'hFFFF_FFFC)); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (imem_bus.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL wrap_next: got %h exp 00000000", imem_bus.imem_addr_o); end
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (imem_bus.imem_req_o !== 1'b0) begin n_err++; $display("FAIL rmid_req: got %b exp 0", imem_bus.imem_req_o); end
    tick();
    n_cmp++; if (pc_if_o !== 32'h0 || instr_if_o !== 32'h0) begin n_err++; $display("FAIL rmid_out: got %h/%h exp 0/0", pc_if_o, instr_if_o); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h0) begin n_err++; $display("FAIL rmid_restart: got %b/%h exp 1/00000000", imem_bus.imem_req_o, imem_bus.imem_addr_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_wait_state();
    test_stall();
    test_jump_acked();
    test_drain();
    test_jump_and_stall();
    test_misalign();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that produces the PC/instruction pair consumed by the IF/ID pipeline register. Owns the fetch PC, runs a req/ack handshake with instruction memory, and obeys the same `jump_flag` (redirect/flush) and `load_use_flag` (stall) signals the IF/ID register sees. When no instruction is ready, it emits a bubble (`zeroword`).

## Interface
- RESET_VEC, 32'h0000_0000, fetch PC after reset (word aligned)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- jump_flag  in  1  redirect request from EX
- jump_addr_i  in  32  redirect target
- load_use_flag  in  1  stall request from hazard unit
- imem_req_o  out  1  instruction memory request
- imem_addr_o  out  32  request address; held stable while imem_req_o=1
- imem_ack_i  in  1  request complete; imem_rdata_i valid this cycle
- imem_rdata_i  in  32  fetched instruction
- pc_if_o  out  32  PC of presented instruction (to pc_if_id_i)
- instr_if_o  out  32  presented instruction or `zeroword` bubble (to instr_if_id_i)
- misalign_o  out  1  only with FETCH_ALIGN_CHECK_EN: redirect target had addr[1:0]≠0

## Operation
- Registers: fetch_pc, req_addr, state, hold buffer (buf_instr, buf_pc), output pair (pc_if_o, instr_if_o).
- States:
  - FETCH: request outstanding at req_addr.
  - HOLD: request done during stall, result buffered, no request.
  - DRAIN: request made stale by a redirect; waiting for ack to discard it.
- imem_req_o = (state==FETCH || state==DRAIN) && !rst. imem_addr_o = req_addr.
- A request never changes address or drops before ack. Ack may arrive in the cycle req rises.
- Per-cycle priority: rst > jump_flag > load_use_flag > normal.
- jump_flag:
  - fetch_pc, req_addr ← target.
  - instr_if_o ← `zeroword`; pc_if_o holds.
  - FETCH&ack → FETCH, data discarded. FETCH&!ack → DRAIN.
  - HOLD → FETCH, buffer discarded. DRAIN stays DRAIN, target updated.
- load_use_flag:
  - Outputs hold.
  - FETCH&ack → buf ← {rdata, req_addr}; fetch_pc += 4; → HOLD.
  - FETCH&!ack stays FETCH. HOLD stays HOLD. DRAIN behaves as in normal.
- Normal:
  - FETCH&ack → outputs ← {req_addr, rdata}; fetch_pc, req_addr ← req_addr+4.
  - FETCH&!ack → instr_if_o ← `zeroword`.
  - HOLD → outputs ← buf; req_addr ← fetch_pc; → FETCH.
  - DRAIN&ack → req_addr ← fetch_pc; → FETCH. DRAIN&!ack stays.
  - DRAIN outputs `zeroword`.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values: fetch_pc=req_addr=RESET_VEC; state=FETCH; pc_if_o=instr_if_o=0; buf=0; misalign_o=0.
- First request is issued in the first cycle after rst deasserts.
- Latency: ack in cycle N → pair visible on outputs at N+1.
- Zero-wait memory gives one instruction per cycle.
- Redirect: target requested in cycle after jump_flag if no request outstanding. Otherwise it follows the drained ack by one cycle.
- Stall release from HOLD: buffered instruction presented next cycle; new request issued the same cycle.
- rst mid-request abandons it; the memory must tolerate a dropped req on reset.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - On an accepted redirect, target[1:0] is forced to 0.
  - misalign_o pulses for one cycle, registered, if the original target[1:0]≠0.
- Undefined:
  - Target is used unmodified; misalign_o is tied to 0.
  - The port remains present so instantiations do not change.

## Structure
- Shared define header (with existing `zeroword`): state encodings FETCH/HOLD/DRAIN, `instr_step` (32'd4), default reset vector.
- One natural sub-module: if_hold_buf. It is a one-entry instruction/PC buffer with load/clear/valid, used for the HOLD path.

## Test plan
- Reset, RESET_VEC=0, ack every cycle → pairs (0,I0),(4,I1),(8,I2) on consecutive cycles; instr_if_o=0 during rst.
- Ack two cycles after req at 0x10 → imem_addr_o steady at 0x10 throughout; two `zeroword` bubbles; then (0x10,Ix).
- load_use_flag for 2 cycles with ack in first → outputs frozen; HOLD entered; on release buffered (PC,instr) appears next cycle, next request at PC+4.
- jump_flag to 0x200 with request at 0x40 unacked → DRAIN; 0x40 data discarded; next request at 0x200; bubbles until 0x200 acked.
- jump_flag and load_use_flag same cycle → jump wins; bubble emitted; fetch restarts at target.
- With FETCH_ALIGN_CHECK_EN, jump to 0x103 → request address 0x100, misalign_o=1 for one cycle. Without the macro, address is 0x103 and misalign_o=0.
